// File: rtl/scp_pkg.sv
// -----------------------------------------------------------------------------
// scp_pkg
// Shared definitions for the scp_079 light controller and its stimulus
// generator: phase codes, the phase-to-light decode and default durations.
// Ports: none (package).
// -----------------------------------------------------------------------------
package scp_pkg;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_GREEN  = 3'd1,
    PH_YELLOW = 3'd2,
    PH_RED    = 3'd3,
    PH_REDYEL = 3'd4,
    PH_CHEAT  = 3'd5
  } phase_t;

  localparam int DEF_GREEN_LEN  = 35;
  localparam int DEF_YELLOW_LEN = 20;
  localparam int DEF_RED_LEN    = 9;
  localparam int DEF_REDYEL_LEN = 11;
  localparam int DEF_CHEAT_LEN  = 4;

  // Light pattern {green, yellow, red} for a phase code.
  function automatic logic [2:0] phase_lights(input phase_t ph);
    case (ph)
      PH_GREEN:  phase_lights = 3'b100;
      PH_YELLOW: phase_lights = 3'b010;
      PH_RED:    phase_lights = 3'b001;
      PH_REDYEL: phase_lights = 3'b011;
      PH_CHEAT:  phase_lights = 3'b111;
      default:   phase_lights = 3'b000;
    endcase
  endfunction

  // Successor in the normal rotation; CHEAT and stray codes fall back to GREEN.
  function automatic phase_t next_phase(input phase_t ph);
    case (ph)
      PH_GREEN:  next_phase = PH_YELLOW;
      PH_YELLOW: next_phase = PH_RED;
      PH_RED:    next_phase = PH_REDYEL;
      default:   next_phase = PH_GREEN;
    endcase
  endfunction

  // Durations are 6-bit; 0 becomes 1 and anything above 63 becomes 63.
  function automatic logic [5:0] clamp_len(input int len);
    if (len < 1)       clamp_len = 6'd1;
    else if (len > 63) clamp_len = 6'd63;
    else               clamp_len = len[5:0];
  endfunction

endpackage

// File: rtl/scp_phase_timer.sv
// -----------------------------------------------------------------------------
// scp_phase_timer
// 6-bit loadable per-phase counter with hold and terminal-count compare.
// Ports:
//   clock, reset_n : clock (rising) and asynchronous active-low reset
//   clear          : load 0 (idle)
//   load           : load 1 (phase entry); clear has priority
//   run            : count up by one, saturating at 63
//   len            : terminal count of the current phase
//   count          : current count
//   tc             : count == len
// -----------------------------------------------------------------------------
module scp_phase_timer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       load,
  input  logic       run,
  input  logic [5:0] len,
  output logic [5:0] count,
  output logic       tc
);

  logic [5:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 6'd0;
    end else if (clear) begin
      count_q <= 6'd0;
    end else if (load) begin
      count_q <= 6'd1;
    end else if (run && (count_q != 6'h3f)) begin
      // The sequencer reloads before 63 is exceeded; saturation is a backstop.
      count_q <= count_q + 6'd1;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == len);

endmodule

// File: rtl/scp_stim_gen.sv
// -----------------------------------------------------------------------------
// scp_stim_gen
// Light/timer stimulus generator for scp_079. Rotates GREEN -> YELLOW -> RED
// -> REDYEL -> GREEN with parameterised durations and a 1-based per-phase
// timer. Optional feature macro: SCP_STIM_CHEAT_EN (adds cheat_req and the
// all-lights-on CHEAT phase entered from GREEN).
// Ports:
//   clock, reset_n        : clock (rising) and asynchronous active-low reset
//   enable                : run sequencer; low forces IDLE on the next edge
//   hold                  : freeze phase and timer
//   skip                  : end current phase at the next edge
//   cheat_req             : request CHEAT burst (SCP_STIM_CHEAT_EN only)
//   green, yellow, red    : light drives decoded from phase
//   timer                 : cycles elapsed in current phase, 1-based (0 in IDLE)
//   phase                 : current phase code (the FSM state)
//   phase_done            : last cycle of the current phase, not held
// -----------------------------------------------------------------------------
module scp_stim_gen
  import scp_pkg::*;
#(
  parameter int GREEN_LEN  = DEF_GREEN_LEN,
  parameter int YELLOW_LEN = DEF_YELLOW_LEN,
  parameter int RED_LEN    = DEF_RED_LEN,
  parameter int REDYEL_LEN = DEF_REDYEL_LEN,
  parameter int CHEAT_LEN  = DEF_CHEAT_LEN
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       hold,
  input  logic       skip,
`ifdef SCP_STIM_CHEAT_EN
  input  logic       cheat_req,
`endif
  output logic       green,
  output logic       yellow,
  output logic       red,
  output logic [5:0] timer,
  output logic [2:0] phase,
  output logic       phase_done
);

  localparam logic [5:0] G_LEN = clamp_len(GREEN_LEN);
  localparam logic [5:0] Y_LEN = clamp_len(YELLOW_LEN);
  localparam logic [5:0] R_LEN = clamp_len(RED_LEN);
  localparam logic [5:0] RY_LEN = clamp_len(REDYEL_LEN);
  localparam logic [5:0] C_LEN = clamp_len(CHEAT_LEN);

  phase_t     phase_q, phase_d;
  logic       t_clear, t_load, t_run;
  logic [5:0] cur_len;
  logic [5:0] count;
  logic       tc;
  logic       cheat_hit;

`ifdef SCP_STIM_CHEAT_EN
  assign cheat_hit = (phase_q == PH_GREEN) && cheat_req;
`else
  assign cheat_hit = 1'b0;
`endif

  always_comb begin
    case (phase_q)
      PH_GREEN:  cur_len = G_LEN;
      PH_YELLOW: cur_len = Y_LEN;
      PH_RED:    cur_len = R_LEN;
      PH_REDYEL: cur_len = RY_LEN;
      PH_CHEAT:  cur_len = C_LEN;
      default:   cur_len = 6'd0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) phase_q <= PH_IDLE;
    else          phase_q <= phase_d;
  end

  // Priority: enable low > leaving IDLE > hold > cheat > skip/expiry > count.
  always_comb begin
    phase_d = phase_q;
    t_clear = 1'b0;
    t_load  = 1'b0;
    t_run   = 1'b0;
    if (!enable) begin
      phase_d = PH_IDLE;
      t_clear = 1'b1;
    end else if (phase_q == PH_IDLE) begin
      phase_d = PH_GREEN;
      t_load  = 1'b1;
    end else if (hold) begin
      phase_d = phase_q;
    end else if (cheat_hit) begin
      phase_d = PH_CHEAT;
      t_load  = 1'b1;
    end else if (skip || tc) begin
      // skip on the expiry cycle still yields exactly one advance
      phase_d = next_phase(phase_q);
      t_load  = 1'b1;
    end else begin
      t_run = 1'b1;
    end
  end

  scp_phase_timer u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (t_clear),
    .load    (t_load),
    .run     (t_run),
    .len     (cur_len),
    .count   (count),
    .tc      (tc)
  );

  assign {green, yellow, red} = phase_lights(phase_q);
  assign timer      = count;
  assign phase      = phase_q;
  // IDLE has len 0 and timer 0, so it is excluded explicitly.
  assign phase_done = (phase_q != PH_IDLE) && tc && !hold;

endmodule

// File: tb/tb_scp_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_scp_stim_gen
// Directed, table-driven bench for scp_stim_gen with default durations.
// Each record sets inputs, advances a number of clocks, then compares
// {phase, timer, lights, phase_done} against hand-computed values.
// -----------------------------------------------------------------------------
module tb_scp_stim_gen;

  typedef struct {
    logic       en;
    logic       hold;
    logic       skip;
    logic       cheat;
    int         cycles;
    logic [2:0] ph;
    logic [5:0] tm;
    logic       dn;
    string      name;
  } vec_t;

  logic clock;
  logic reset_n;
  logic enable;
  logic hold;
  logic skip;
`ifdef SCP_STIM_CHEAT_EN
  logic cheat_req;
`endif
  logic       green, yellow, red;
  logic [5:0] timer;
  logic [2:0] phase;
  logic       phase_done;

  int total = 0;
  int bad   = 0;
  vec_t vecs[80];
  int   n_vec = 0;
  logic [12:0] exp_q[$];

  scp_stim_gen dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .hold       (hold),
    .skip       (skip),
`ifdef SCP_STIM_CHEAT_EN
    .cheat_req  (cheat_req),
`endif
    .green      (green),
    .yellow     (yellow),
    .red        (red),
    .timer      (timer),
    .phase      (phase),
    .phase_done (phase_done)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [2:0] exp_lights(input logic [2:0] ph);
    case (ph)
      3'd1:    exp_lights = 3'b100;
      3'd2:    exp_lights = 3'b010;
      3'd3:    exp_lights = 3'b001;
      3'd4:    exp_lights = 3'b011;
      3'd5:    exp_lights = 3'b111;
      default: exp_lights = 3'b000;
    endcase
  endfunction

  function automatic logic [12:0] pack_exp(input logic [2:0] ph, input logic [5:0] tm,
                                           input logic dn);
    pack_exp = {ph, tm, exp_lights(ph), dn};
  endfunction

  task automatic add_vec(input logic en, input logic hd, input logic sk, input logic ch,
                         input int cyc, input logic [2:0] ph, input logic [5:0] tm,
                         input logic dn, input string nm);
    vecs[n_vec] = '{en, hd, sk, ch, cyc, ph, tm, dn, nm};
    n_vec++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // scoreboard: pop the oldest expectation and compare against the DUT
  task automatic check_out(input string nm);
    logic [12:0] act;
    logic [12:0] exp;
    act = {phase, timer, green, yellow, red, phase_done};
    exp = exp_q.pop_front();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got ph=%0d tm=%0d gyr=%b done=%b, want ph=%0d tm=%0d gyr=%b done=%b",
               nm, act[12:10], act[9:4], act[3:1], act[0],
               exp[12:10], exp[9:4], exp[3:1], exp[0]);
    end
  endtask

  task automatic check_val(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      enable = vecs[i].en;
      hold   = vecs[i].hold;
      skip   = vecs[i].skip;
`ifdef SCP_STIM_CHEAT_EN
      cheat_req = vecs[i].cheat;
`endif
      exp_q.push_back(pack_exp(vecs[i].ph, vecs[i].tm, vecs[i].dn));
      step(vecs[i].cycles);
      check_out(vecs[i].name);
    end
    hold = 1'b0;
    skip = 1'b0;
`ifdef SCP_STIM_CHEAT_EN
    cheat_req = 1'b0;
`endif
  endtask

  initial begin
    int first_hi;
    int done_cnt;

    // main rotation, skip, hold, enable drop
    add_vec(1, 0, 0, 0,  1, 3'd1,  1, 0, "en_to_green");
    add_vec(1, 0, 0, 0, 34, 3'd1, 35, 1, "green_last");
    add_vec(1, 0, 0, 0,  1, 3'd2,  1, 0, "yellow_first");
    add_vec(1, 0, 0, 0, 19, 3'd2, 20, 1, "yellow_last");
    add_vec(1, 0, 0, 0,  1, 3'd3,  1, 0, "red_first");
    add_vec(1, 0, 0, 0,  8, 3'd3,  9, 1, "red_last");
    add_vec(1, 0, 0, 0,  1, 3'd4,  1, 0, "redyel_first");
    add_vec(1, 0, 0, 0, 10, 3'd4, 11, 1, "redyel_last");
    add_vec(1, 0, 0, 0,  1, 3'd1,  1, 0, "green_cycle76");
    first_hi = n_vec;
    add_vec(1, 0, 0, 0,  9, 3'd1, 10, 0, "green_t10");
    add_vec(1, 0, 1, 0,  1, 3'd2,  1, 0, "skip_to_yellow");
    add_vec(1, 0, 0, 0,  6, 3'd2,  7, 0, "yellow_t7");
    add_vec(1, 1, 0, 0,  5, 3'd2,  7, 0, "hold_5");
    add_vec(1, 1, 1, 0,  1, 3'd2,  7, 0, "hold_skip");
    add_vec(1, 0, 0, 0,  1, 3'd2,  8, 0, "hold_release");
    add_vec(1, 0, 0, 0, 12, 3'd2, 20, 1, "yellow_last2");
    add_vec(1, 0, 1, 0,  1, 3'd3,  1, 0, "skip_at_len");
    add_vec(1, 0, 0, 0,  1, 3'd3,  2, 0, "single_advance");
    add_vec(1, 0, 0, 0,  2, 3'd3,  4, 0, "red_t4");
    add_vec(0, 0, 0, 0,  1, 3'd0,  0, 0, "enable_drop");
    add_vec(0, 0, 0, 0,  3, 3'd0,  0, 0, "idle_stays");
    add_vec(1, 0, 0, 0,  1, 3'd1,  1, 0, "re_enable");
    add_vec(1, 0, 0, 0, 34, 3'd1, 35, 1, "green_last2");
    add_vec(1, 1, 0, 0,  2, 3'd1, 35, 0, "hold_at_len");
    add_vec(1, 0, 0, 0,  1, 3'd2,  1, 0, "after_hold_len");
    add_vec(1, 0, 0, 0, 19, 3'd2, 20, 1, "yellow_last3");
    add_vec(1, 0, 0, 0,  9, 3'd3,  9, 1, "red_last2");
    add_vec(1, 0, 0, 0,  5, 3'd4,  5, 0, "redyel_t5");

    enable  = 1'b0;
    hold    = 1'b0;
    skip    = 1'b0;
`ifdef SCP_STIM_CHEAT_EN
    cheat_req = 1'b0;
`endif
    reset_n = 1'b0;
    step(2);
    exp_q.push_back(pack_exp(3'd0, 6'd0, 1'b0));
    check_out("reset_state");
    reset_n = 1'b1;
    step(2);
    exp_q.push_back(pack_exp(3'd0, 6'd0, 1'b0));
    check_out("idle_after_reset");

    // full rotation, then count phase_done pulses over one 75-cycle loop
    apply_range(0, first_hi);
    done_cnt = 0;
    for (int i = 0; i < 75; i++) begin
      if (phase_done) done_cnt++;
      step(1);
    end
    check_val("done_pulses", done_cnt, 4);
    exp_q.push_back(pack_exp(3'd1, 6'd1, 1'b0));
    check_out("loop_back_green");

    apply_range(first_hi, n_vec);

    // reset asserted between edges: outputs clear without a clock edge
    #3;
    reset_n = 1'b0;
    #1;
    exp_q.push_back(pack_exp(3'd0, 6'd0, 1'b0));
    check_out("async_reset");
    enable = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    step(2);
    exp_q.push_back(pack_exp(3'd0, 6'd0, 1'b0));
    check_out("idle_after_release");
    enable = 1'b1;
    step(1);
    exp_q.push_back(pack_exp(3'd1, 6'd1, 1'b0));
    check_out("green_after_release");

`ifdef SCP_STIM_CHEAT_EN
    first_hi = n_vec;
    add_vec(1, 0, 0, 0, 19, 3'd1, 20, 0, "green_t20");
    add_vec(1, 0, 0, 1,  1, 3'd5,  1, 0, "cheat_enter");
    add_vec(1, 0, 0, 0,  3, 3'd5,  4, 1, "cheat_last");
    add_vec(1, 0, 0, 0,  1, 3'd1,  1, 0, "cheat_to_green");
    add_vec(1, 0, 0, 0,  1, 3'd1,  2, 0, "green_t2");
    add_vec(1, 0, 1, 1,  1, 3'd5,  1, 0, "cheat_beats_skip");
    add_vec(1, 0, 1, 0,  1, 3'd1,  1, 0, "skip_in_cheat");
    add_vec(1, 0, 0, 0, 34, 3'd1, 35, 1, "green_last_c");
    add_vec(1, 0, 0, 0, 20, 3'd2, 20, 1, "yellow_last_c");
    add_vec(1, 0, 0, 0,  1, 3'd3,  1, 0, "red_first_c");
    add_vec(1, 0, 0, 1,  3, 3'd3,  4, 0, "cheat_in_red");
    apply_range(first_hi, n_vec);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scp_stim_gen.md
# scp_stim_gen

Drives the light and timer inputs consumed by the scp_079 controller. It sequences green, yellow, red and red+yellow phases with parameterised durations. It produces the 6-bit per-phase `timer` count that scp_079 expects: restarting at 1 on every phase entry and counting up once per clock. It replaces hand-written bench stimulus and sits between the board-level enable/skip controls and scp_079.

## Interface
- `GREEN_LEN`, 35, green-phase duration in cycles (1..63)
- `YELLOW_LEN`, 20, yellow-phase duration (1..63)
- `RED_LEN`, 9, red-phase duration (1..63)
- `REDYEL_LEN`, 11, red+yellow-phase duration (1..63)
- `CHEAT_LEN`, 4, all-lights-on burst duration (1..63; used only with `SCP_STIM_CHEAT_EN`)
- `clock`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `enable`  in  1  run sequencer; low forces IDLE
- `hold`  in  1  freeze timer and phase while high
- `skip`  in  1  single-cycle pulse: end current phase early
- `cheat_req`  in  1  request all-on burst (present only with `SCP_STIM_CHEAT_EN`)
- `green`, `yellow`, `red`  out  1 each  light drives to scp_079
- `timer`  out  6  cycles elapsed in current phase, 1-based
- `phase`  out  3  current phase code
- `phase_done`  out  1  high on the last cycle of each phase

## Operation
- Phase codes and lights (g/y/r):
  - IDLE=0 → 0/0/0
  - GREEN=1 → 1/0/0
  - YELLOW=2 → 0/1/0
  - RED=3 → 0/0/1
  - REDYEL=4 → 0/1/1
  - CHEAT=5 → 1/1/1
- Cycle order: IDLE → GREEN → YELLOW → RED → REDYEL → GREEN → …; IDLE is never re-entered while `enable`=1.
- Lights decode combinationally from the registered `phase`. `timer` and `phase` are registered.
- `timer` holds 1..LEN of the current phase. `phase_done` = (`timer`==LEN) && !`hold`.
- On a `phase_done` cycle, the next edge loads the next phase with `timer`=1.
- `skip`=1 (and `hold`=0) ends the phase at the next edge regardless of `timer`. `skip` coincident with `phase_done` causes exactly one advance.
- `hold` has priority over `skip` and natural expiry. While held, `timer`, `phase` and lights are frozen and `phase_done`=0.
- `enable`=0: the next edge forces IDLE with `timer`=0, overriding everything. This also applies mid-phase.
- `timer` arithmetic is 6-bit unsigned and never wraps. The sequencer reloads 1 before 63+1 can occur.
- A LEN of 0 is clamped to 1 at elaboration.

## Timing
- Reset (async assert, sync release): `phase`=IDLE, `timer`=0, lights 0, `phase_done`=0.
- `enable` rising with the sequencer in IDLE: next edge gives GREEN, `timer`=1. First light output follows 1 cycle after `enable`.
- A phase of length L occupies exactly L cycles absent `hold`/`skip`.
- A full default cycle lasts 35+20+9+11=75 cycles.
- `skip` latency: 1 cycle to the new phase.
- Reset asserted mid-phase: outputs reach reset values immediately, without waiting for a clock edge.

## Configuration
- Macro: `SCP_STIM_CHEAT_EN`.
- Defined:
  - `cheat_req` port exists.
  - `cheat_req`=1 during GREEN (and `hold`=0) enters CHEAT at the next edge with `timer`=1.
  - CHEAT lasts `CHEAT_LEN` cycles with all lights on, then returns to GREEN with `timer`=1 (full green restarts).
  - `skip` in CHEAT returns to GREEN.
  - `cheat_req` outside GREEN is ignored.
  - `cheat_req` and `skip` in the same GREEN cycle: cheat wins.
- Undefined: no `cheat_req` port, code 5 is unreachable, and the all-on pattern is never produced.

## Structure
- Shared package `scp_pkg` holds:
  - phase code constants (IDLE..CHEAT, 3-bit)
  - the light-pattern decode function
  - the default duration constants
- scp_079 imports the same phase/light constants.
- One sub-module, `scp_phase_timer`:
  - 6-bit loadable counter with hold and terminal-count compare
  - instantiated once
  - the FSM owns the load/next-phase logic

## Test plan
- Reset, then `enable`=1 with defaults → GREEN `timer` 1..35, YELLOW 1..20, RED 1..9, REDYEL 1..11, then GREEN `timer`=1 at cycle 76; `phase_done` exactly 4 pulses.
- `skip` pulse at GREEN `timer`=10 → next cycle YELLOW `timer`=1; `skip` at `timer`==LEN → single advance only.
- `hold` high for 5 cycles at YELLOW `timer`=7 → `timer` stays 7, no `phase_done`; `hold`+`skip` together → no advance.
- `enable` dropped at RED `timer`=4 → next edge IDLE, `timer`=0, lights 0; re-enable → GREEN `timer`=1.
- `reset_n` low mid-REDYEL between edges → outputs 0 immediately; release → IDLE until the next enabled edge.
- With `SCP_STIM_CHEAT_EN`: `cheat_req` at GREEN `timer`=20 → 4 cycles g/y/r=1/1/1, then GREEN `timer`=1; `cheat_req` during RED → ignored.
